// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs a stream of dw-bit lanes into N-lane words. Lanes fill an accumulator
// in arrival order (first lane in bits [dw-1:0]); the lane that fills the last
// slot moves the whole word into a registered output slot in the same edge.
//
// Optional feature macro: PACK_FLUSH_EN
//   When defined, a 'flush' input emits the current partial word with a
//   keep_out mask covering only the filled lanes. If the output slot is
//   occupied and not draining, the flush is remembered in a pending flag and
//   input is stalled until the partial word can be emitted.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   d_in     : input lane data (dw bits)
//   req_in   : upstream has valid data on d_in
//   ack_in   : packer can take d_in this cycle
//   d_out    : packed word (dw*N bits), lane 0 in the low bits
//   keep_out : per-lane valid mask for d_out
//   req_out  : d_out/keep_out hold a valid word
//   ack_out  : downstream takes the word this cycle
//   flush    : emit the partial word (PACK_FLUSH_EN builds only)
// -----------------------------------------------------------------------------
module byte_packer #(
    parameter int dw = 8,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [dw-1:0]   d_in,
    input  logic            req_in,
    output logic            ack_in,
    output logic [dw*N-1:0] d_out,
    output logic [N-1:0]    keep_out,
    output logic            req_out,
    input  logic            ack_out
`ifdef PACK_FLUSH_EN
    ,
    input  logic            flush
`endif
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]   r_cnt;
    logic [dw*N-1:0] r_acc;
    logic [dw*N-1:0] r_dout;
    logic [N-1:0]    r_keep;
    logic            r_req;

    logic            w_take;
    logic            w_complete;
    logic            w_full_load;
    logic            w_drain;
    logic            w_slot_free;
    logic [dw*N-1:0] w_acc_ins;

    assign w_take      = req_in & ack_in;
    // The next accepted lane is the one that finishes the word.
    assign w_complete  = (r_cnt == LAST);
    assign w_full_load = w_take & w_complete;
    assign w_drain     = r_req & ack_out;
    // Output slot can take a new word this edge: empty or being drained.
    assign w_slot_free = ~r_req | ack_out;

`ifdef PACK_FLUSH_EN
    logic            r_pend;
    logic [CW:0]     w_cnt_eff;
    logic [dw*N-1:0] w_acc_new;
    logic [N-1:0]    w_keep_part;
    logic            w_has_part;
    logic            w_flush_emit;
    logic            w_pend_set;

    // Lane count including any lane accepted on this edge.
    assign w_cnt_eff    = {1'b0, r_cnt} + {{CW{1'b0}}, w_take};
    assign w_acc_new    = w_take ? w_acc_ins : r_acc;
    assign w_keep_part  = ~({N{1'b1}} << w_cnt_eff);
    assign w_has_part   = (w_cnt_eff != {(CW+1){1'b0}});
    // A completing lane wins over a coincident flush (flush becomes a no-op).
    assign w_flush_emit = ~w_full_load & w_slot_free & (r_pend | (flush & w_has_part));
    assign w_pend_set   = ~w_full_load & ~w_slot_free & ~r_pend & flush & w_has_part;

    // Stall input when the completing lane has nowhere to go or a flush waits.
    assign ack_in = ~((w_complete & r_req & ~ack_out) | r_pend);
`else
    // Stall input only when the completing lane has nowhere to go.
    assign ack_in = ~(w_complete & r_req & ~ack_out);
`endif

    // Accumulator with the incoming lane written into slot r_cnt.
    always_comb begin
        w_acc_ins = r_acc;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_acc_ins[i*dw +: dw] = d_in;
            end else begin
                w_acc_ins[i*dw +: dw] = r_acc[i*dw +: dw];
            end
        end
    end

    // Accumulator, lane counter, output slot and flush-pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= {CW{1'b0}};
            r_acc  <= {(dw*N){1'b0}};
            r_dout <= {(dw*N){1'b0}};
            r_keep <= {N{1'b0}};
            r_req  <= 1'b0;
`ifdef PACK_FLUSH_EN
            r_pend <= 1'b0;
`endif
        end else begin
            if (w_full_load) begin
                r_dout <= w_acc_ins;
                r_keep <= {N{1'b1}};
                r_req  <= 1'b1;
                r_cnt  <= {CW{1'b0}};
                r_acc  <= {(dw*N){1'b0}};
`ifdef PACK_FLUSH_EN
            end else if (w_flush_emit) begin
                // Unfilled lanes are already zero: the accumulator is cleared
                // every time a word leaves it.
                r_dout <= w_acc_new;
                r_keep <= w_keep_part;
                r_req  <= 1'b1;
                r_cnt  <= {CW{1'b0}};
                r_acc  <= {(dw*N){1'b0}};
`endif
            end else begin
                if (w_drain) begin
                    r_req <= 1'b0;
                end else begin
                    r_req <= r_req;
                end
                if (w_take) begin
                    r_acc <= w_acc_ins;
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_acc <= r_acc;
                    r_cnt <= r_cnt;
                end
            end
`ifdef PACK_FLUSH_EN
            if (w_flush_emit) begin
                r_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
`endif
        end
    end

    assign d_out    = r_dout;
    assign keep_out = r_keep;
    assign req_out  = r_req;

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  d_in;
    logic        req_in;
    logic        ack_in;
    logic [31:0] d_out;
    logic [3:0]  keep_out;
    logic        req_out;
    logic        ack_out;
    logic        flush;

    int n_checks;
    int n_fail;

    byte_packer #(.dw(8), .N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .d_out    (d_out),
        .keep_out (keep_out),
        .req_out  (req_out),
        .ack_out  (ack_out)
`ifdef PACK_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte for one edge (caller ensures ack_in is high).
    task automatic send(input logic [7:0] b);
        d_in   = b;
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b0; ack_out = 1'b0; flush = 1'b0; d_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req_out got %b want 0", req_out); end
        n_checks++; if (d_out !== 32'h0) begin n_fail++; $display("FAIL reset_d_out got %h want 0", d_out); end
        n_checks++; if (keep_out !== 4'b0000) begin n_fail++; $display("FAIL reset_keep got %b want 0000", keep_out); end
        n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL reset_ack_in got %b want 1", ack_in); end
    endtask

    task automatic test_basic();
        logic [7:0] v [4];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
        ack_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = v[i]; req_in = 1'b1; #1;
            n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL basic_ack_in[%0d] got %b want 1", i, ack_in); end
            n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL basic_early_req[%0d] got %b want 0", i, req_out); end
            tick();
        end
        req_in = 1'b0;
        n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL basic_req_out got %b want 1", req_out); end
        n_checks++; if (d_out !== 32'h44332211) begin n_fail++; $display("FAIL basic_d_out got %h want 44332211", d_out); end
        n_checks++; if (keep_out !== 4'b1111) begin n_fail++; $display("FAIL basic_keep got %b want 1111", keep_out); end
        tick();
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop got %b want 0", req_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        int words;
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09;
        words = 0;
        ack_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d_in = 8'(i + 1); req_in = 1'b1; #1;
            n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_in[%0d] got %b want 1", i, ack_in); end
            tick();
            n_checks++; if (req_out !== ((i % 4) == 3)) begin n_fail++; $display("FAIL b2b_req_out[%0d] got %b want %b", i, req_out, ((i % 4) == 3)); end
            if ((i % 4) == 3) begin
                n_checks++; if (d_out !== exp_w[words]) begin n_fail++; $display("FAIL b2b_word[%0d] got %h want %h", words, d_out, exp_w[words]); end
                words++;
            end
        end
        req_in = 1'b0;
        tick();
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", req_out); end
    endtask

    task automatic test_backpressure();
        ack_out = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d_in = 8'h51 + 8'(i); req_in = 1'b1; #1;
            n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL bp_ack_in[%0d] got %b want 1", i, ack_in); end
            tick();
            if (i >= 3) begin
                n_checks++; if (d_out !== 32'h54535251 || req_out !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %h/%b want 54535251/1", i, d_out, req_out); end
            end
        end
        d_in = 8'h58; req_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (ack_in !== 1'b0) begin n_fail++; $display("FAIL bp_stall[%0d] got %b want 0", i, ack_in); end
            tick();
            n_checks++; if (d_out !== 32'h54535251 || keep_out !== 4'b1111) begin n_fail++; $display("FAIL bp_stable[%0d] got %h/%b want 54535251/1111", i, d_out, keep_out); end
        end
        ack_out = 1'b1; #1;
        n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", ack_in); end
        tick();
        req_in = 1'b0;
        n_checks++; if (req_out !== 1'b1 || d_out !== 32'h58575655) begin n_fail++; $display("FAIL bp_word2 got %b/%h want 1/58575655", req_out, d_out); end
        tick();
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", req_out); end
    endtask

    task automatic test_reset_mid();
        ack_out = 1'b0;
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        send(8'hDE); send(8'hAD);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        n_checks++; if (req_out !== 1'b0 || d_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_out got %b/%h want 0/0", req_out, d_out); end
        n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack_in got %b want 1", ack_in); end
        ack_out = 1'b1;
        send(8'h01); send(8'h02); send(8'h03);
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got %b want 0", req_out); end
        send(8'h04);
        n_checks++; if (req_out !== 1'b1 || d_out !== 32'h04030201) begin n_fail++; $display("FAIL rstmid_word got %b/%h want 1/04030201", req_out, d_out); end
        tick();
    endtask

`ifdef PACK_FLUSH_EN
    task automatic test_flush();
        ack_out = 1'b1;
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL flush_noop got %b want 0", req_out); end
        send(8'hAA); send(8'hBB);
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (req_out !== 1'b1 || d_out !== 32'h0000BBAA || keep_out !== 4'b0011) begin n_fail++; $display("FAIL flush_part got %b/%h/%b want 1/0000bbaa/0011", req_out, d_out, keep_out); end
        send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
        n_checks++; if (d_out !== 32'hFFEEDDCC || keep_out !== 4'b1111) begin n_fail++; $display("FAIL flush_next got %h/%b want ffeeddcc/1111", d_out, keep_out); end
        tick();
    endtask

    task automatic test_flush_pending();
        ack_out = 1'b0;
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        send(8'h77);
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (ack_in !== 1'b0) begin n_fail++; $display("FAIL pend_ack_in[%0d] got %b want 0", i, ack_in); end
            n_checks++; if (d_out !== 32'h64636261) begin n_fail++; $display("FAIL pend_hold[%0d] got %h want 64636261", i, d_out); end
            tick();
        end
        ack_out = 1'b1; #1;
        n_checks++; if (ack_in !== 1'b0) begin n_fail++; $display("FAIL pend_ack_drain got %b want 0", ack_in); end
        tick();
        n_checks++; if (req_out !== 1'b1 || d_out !== 32'h00000077 || keep_out !== 4'b0001) begin n_fail++; $display("FAIL pend_emit got %b/%h/%b want 1/00000077/0001", req_out, d_out, keep_out); end
        n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL pend_clear got %b want 1", ack_in); end
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef PACK_FLUSH_EN
        test_flush();
        test_flush_pending();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
